// File: rtl/wb_byte_loader.sv
// Byte-stream to Wishbone master bridge.
// Decodes framed commands (CMD, ADR_LO, ADR_HI, LEN, payload) into single-beat
// classic Wishbone writes/reads with auto-incrementing word address. Read data
// is returned least-significant byte first on the tx byte stream.
module wb_byte_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_cyc_o,
  input  logic                    wbm_ack_i,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR0, S_ADR1, S_LEN, S_WDATA, S_WBWR, S_WBRD, S_RDATA
  } state_t;

  localparam logic [7:0]            CMD_WR   = 8'h01;
  localparam logic [7:0]            CMD_RD   = 8'h02;
  localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADR_MASK = ~ADDR_WIDTH'(3);

  state_t                  state_q, state_d;
  logic                    is_wr_q, is_wr_d;
  logic [7:0]              adr_lo_q, adr_lo_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [7:0]              cnt_q, cnt_d;     // words remaining after the current one
  logic [1:0]              lane_q, lane_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;   // write assembly / read holding buffer
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   dat_o_q, dat_o_d;
  logic                    err_q, err_d;

  logic rx_fire, tx_fire;

  // Handshake signals decode straight from the state register.
  always_comb begin
    rx_ready = (state_q == S_IDLE) || (state_q == S_ADR0) || (state_q == S_ADR1) ||
               (state_q == S_LEN)  || (state_q == S_WDATA);
    tx_valid = (state_q == S_RDATA);
    rx_fire  = rx_valid & rx_ready;
    tx_fire  = tx_valid & tx_ready;
  end

  assign tx_data   = word_q[{lane_q, 3'b000} +: 8];
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_o_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = cyc_q;

  // Next-state and registered bus outputs; bus signals are set on the edge
  // entering a bus state and cleared on the edge that samples ack.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    adr_lo_d = adr_lo_q;
    adr_d    = adr_q;
    cnt_d    = cnt_q;
    lane_d   = lane_q;
    word_d   = word_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    we_d     = we_q;
    sel_d    = sel_q;
    dat_o_d  = dat_o_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
          is_wr_d = (rx_data == CMD_WR);
          state_d = S_ADR0;
        end else begin
          err_d = 1'b1;
        end
      end
      S_ADR0: if (rx_fire) begin
        adr_lo_d = rx_data;
        state_d  = S_ADR1;
      end
      S_ADR1: if (rx_fire) begin
        adr_d   = ADDR_WIDTH'({rx_data, adr_lo_q}) & ADR_MASK;
        state_d = S_LEN;
      end
      S_LEN: if (rx_fire) begin
        cnt_d  = rx_data;
        lane_d = 2'd0;
        if (is_wr_q) begin
          state_d = S_WDATA;
        end else begin
          state_d = S_WBRD;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          sel_d   = '1;
        end
      end
      S_WDATA: if (rx_fire) begin
        word_d[{lane_q, 3'b000} +: 8] = rx_data;
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          state_d = S_WBWR;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          sel_d   = '1;
          dat_o_d = {rx_data, word_q[DATA_WIDTH-9:0]};
        end
      end
      S_WBWR: if (wbm_ack_i) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = '0;
        dat_o_d = '0;
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          adr_d   = adr_q + ADR_STEP;
          cnt_d   = cnt_q - 8'd1;
          state_d = S_WDATA;
        end
      end
      S_WBRD: if (wbm_ack_i) begin
        word_d  = wbm_dat_i;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        sel_d   = '0;
        lane_d  = 2'd0;
        state_d = S_RDATA;
      end
      S_RDATA: if (tx_fire) begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          if (cnt_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            adr_d   = adr_q + ADR_STEP;
            cnt_d   = cnt_q - 8'd1;
            state_d = S_WBRD;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            sel_d   = '1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame and drops the bus immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_wr_q  <= 1'b0;
      adr_lo_q <= '0;
      adr_q    <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_o_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      adr_lo_q <= adr_lo_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      dat_o_q  <= dat_o_d;
      err_q    <= err_d;
    end
  end

endmodule
